// File: rtl/instr_sequencer_if.sv
// Control/strobe bundle between the instruction sequencer (slave) and its environment (master).
interface instr_sequencer_if #(
    parameter int RETIRE_W = 16
);
    logic                start;
    logic [1:0]          opcode;
    logic                cmp;
    logic                mem_ready;
    logic [2:0]          state;
    logic [3:0]          count;
    logic                fetch_en;
    logic                alu_en;
    logic                mem_req;
    logic                wb_en;
    logic                pc_inc;
    logic                pc_load;
    logic                halted;
    logic                err;
    logic [RETIRE_W-1:0] retired;

    modport master (
        output start, opcode, cmp, mem_ready,
        input  state, count, fetch_en, alu_en, mem_req, wb_en, pc_inc, pc_load,
               halted, err, retired
    );

    modport slave (
        input  start, opcode, cmp, mem_ready,
        output state, count, fetch_en, alu_en, mem_req, wb_en, pc_inc, pc_load,
               halted, err, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// Cycle-level control FSM of the processor: fetch/decode/execute sequencing, retire counter.
// Define INSTR_SEQ_TIMEOUT_EN to halt with a sticky err when FETCH or MEM waits out its count.
module instr_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_BRANCH = 3'd5,
        S_WRITE  = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [1:0] OP_ALU  = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_e              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [1:0]          op_q, op_d;
    logic                cmp_q, cmp_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
`ifdef INSTR_SEQ_TIMEOUT_EN
    logic                err_q, err_d;
    logic                timeout;

    assign timeout = (state_q == S_FETCH || state_q == S_MEM) &&
                     (count_q == 4'hF) && !bus.mem_ready;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        cmp_d     = cmp_q;
        retired_d = retired_q;
`ifdef INSTR_SEQ_TIMEOUT_EN
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d  = bus.opcode;
                cmp_d = bus.cmp;
                case (bus.opcode)
                    OP_ALU:  state_d = S_EXEC;
                    OP_MEM:  state_d = S_MEM;
                    OP_JMP:  state_d = bus.cmp ? S_BRANCH : S_WRITE;
                    OP_HALT: state_d = S_HALT;
                endcase
            end
            S_EXEC:   if (count_q == 4'd1) state_d = S_WRITE;
            S_MEM:    if (bus.mem_ready) state_d = S_WRITE;
            S_BRANCH, S_WRITE: begin
                state_d   = S_FETCH;
                retired_d = retired_q + RETIRE_W'(1);
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

`ifdef INSTR_SEQ_TIMEOUT_EN
        // mem_ready on the count==15 cycle already kept timeout low, so the normal move wins.
        if (timeout) begin
            state_d = S_HALT;
            err_d   = 1'b1;
        end
`endif

        if (state_d != state_q || state_q == S_IDLE || state_q == S_HALT)
            count_d = 4'd0;
        else if (count_q != 4'hF)
            count_d = count_q + 4'd1;
        else
            count_d = count_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= 4'd0;
            op_q      <= 2'b00;
            cmp_q     <= 1'b0;
            retired_q <= '0;
`ifdef INSTR_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            cmp_q     <= cmp_d;
            retired_q <= retired_d;
`ifdef INSTR_SEQ_TIMEOUT_EN
            err_q     <= err_d;
`endif
        end
    end

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.fetch_en = (state_q == S_FETCH);
    assign bus.alu_en   = (state_q == S_EXEC);
    assign bus.mem_req  = (state_q == S_MEM);
    assign bus.wb_en    = (state_q == S_WRITE) && (op_q != OP_JMP);
    assign bus.pc_inc   = (state_q == S_WRITE);
    assign bus.pc_load  = (state_q == S_BRANCH);
    assign bus.halted   = (state_q == S_HALT);
    assign bus.retired  = retired_q;
`ifdef INSTR_SEQ_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: an instruction-level model expands each instruction into
// its expected per-cycle trace, and a compare process checks every output on every cycle.
module tb_instr_sequencer;

    localparam int RW        = 16;
    localparam int ST_IDLE   = 0;
    localparam int ST_FETCH  = 1;
    localparam int ST_DECODE = 2;
    localparam int ST_EXEC   = 3;
    localparam int ST_MEM    = 4;
    localparam int ST_BRANCH = 5;
    localparam int ST_WRITE  = 6;
    localparam int ST_HALT   = 7;

    logic clk = 1'b0;
    logic rst;

    instr_sequencer_if #(.RETIRE_W(RW)) bus ();
    instr_sequencer #(.RETIRE_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int cnt;
        bit wbf;
        int ret;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m_ret    = 0;
    bit   m_err    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs are compared mid-cycle against the trace entry pushed for this cycle.
    initial begin : compare_proc
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",    bus.state,    e.st);
                check("count",    bus.count,    e.cnt);
                check("fetch_en", bus.fetch_en, e.st == ST_FETCH);
                check("alu_en",   bus.alu_en,   e.st == ST_EXEC);
                check("mem_req",  bus.mem_req,  e.st == ST_MEM);
                check("wb_en",    bus.wb_en,    e.st == ST_WRITE && e.wbf);
                check("pc_inc",   bus.pc_inc,   e.st == ST_WRITE);
                check("pc_load",  bus.pc_load,  e.st == ST_BRANCH);
                check("halted",   bus.halted,   e.st == ST_HALT);
                check("err",      bus.err,      e.err);
                check("retired",  bus.retired,  e.ret % (1 << RW));
            end
        end
    end

    task automatic cycle(input int st, input int cnt, input bit wbf, input bit s,
                         input logic [1:0] op, input bit c, input bit mr);
        exp_t e;
        e.st = st; e.cnt = cnt; e.wbf = wbf; e.ret = m_ret; e.err = m_err;
        exp_q.push_back(e);
        bus.start = s; bus.opcode = op; bus.cmp = c; bus.mem_ready = mr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Non-decode cycles carry a halt opcode and cmp=1 as junk the DUT must ignore.
    task automatic step(input int st, input int cnt, input bit mr);
        cycle(st, cnt, 1'b0, 1'b0, 2'b11, 1'b1, mr);
    endtask

    task automatic retire(input int st, input bit wbf);
        cycle(st, 0, wbf, 1'b0, 2'b11, 1'b1, 1'b1);
        m_ret++;
    endtask

    task automatic start_seq();
        cycle(ST_IDLE, 0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    endtask

    task automatic wait_phase(input int st, input int nlow, input bit rel, output bit to);
        int cnt;
        to = 1'b0;
        for (int i = 0; i < nlow; i++) begin
            cnt = (i > 15) ? 15 : i;
`ifdef INSTR_SEQ_TIMEOUT_EN
            if (cnt == 15) begin
                step(st, 15, 1'b0);
                m_err = 1'b1;
                to    = 1'b1;
                return;
            end
`endif
            step(st, cnt, 1'b0);
        end
        if (rel) step(st, (nlow > 15) ? 15 : nlow, 1'b1);
    endtask

    task automatic rest(input logic [1:0] op, input bit c, input int mwait);
        bit to;
        cycle(ST_DECODE, 0, 1'b0, 1'b0, op, c, 1'b1);
        case (op)
            2'b00: begin
                step(ST_EXEC, 0, 1'b1);
                step(ST_EXEC, 1, 1'b1);
                retire(ST_WRITE, 1'b1);
            end
            2'b01: begin
                wait_phase(ST_MEM, mwait, 1'b1, to);
                if (!to) retire(ST_WRITE, 1'b1);
            end
            2'b10: if (c) retire(ST_BRANCH, 1'b0); else retire(ST_WRITE, 1'b0);
            default: ;
        endcase
    endtask

    task automatic instr(input int fwait, input logic [1:0] op, input bit c, input int mwait,
                         output int ncyc);
        bit to;
        int c0;
        c0 = cyc;
        wait_phase(ST_FETCH, fwait, 1'b1, to);
        if (!to) rest(op, c, mwait);
        ncyc = cyc - c0;
    endtask

    // start toggles and opcode 00 with mem_ready high must not disturb HALT.
    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++)
            cycle(ST_HALT, 0, 1'b0, (i % 2) == 0, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},    bus.state,    0);
        check({tag, "_count"},    bus.count,    0);
        check({tag, "_fetch_en"}, bus.fetch_en, 0);
        check({tag, "_alu_en"},   bus.alu_en,   0);
        check({tag, "_mem_req"},  bus.mem_req,  0);
        check({tag, "_wb_en"},    bus.wb_en,    0);
        check({tag, "_pc_inc"},   bus.pc_inc,   0);
        check({tag, "_pc_load"},  bus.pc_load,  0);
        check({tag, "_halted"},   bus.halted,   0);
        check({tag, "_err"},      bus.err,      0);
        check({tag, "_retired"},  bus.retired,  0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        m_ret = 0;
        m_err = 1'b0;
        check_reset_vals(tag);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bit to;
        rst = 1'b1;
        bus.start = 1'b0; bus.opcode = 2'b00; bus.cmp = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("por");

        step(ST_IDLE, 0, 1'b1);
        step(ST_IDLE, 0, 1'b1);
        start_seq();
        instr(0, 2'b00, 1'b0, 0, n);
        check("alu_latency", n, 5);
        check("alu_retired", bus.retired, 1);
        check("alu_next_state", bus.state, ST_FETCH);

        apply_reset("rst1");
        start_seq();
        instr(0, 2'b10, 1'b1, 0, n);
        check("jmp_taken_latency", n, 3);
        instr(0, 2'b10, 1'b0, 0, n);
        check("jmp_not_taken_latency", n, 3);
        check("jmp_retired", bus.retired, 2);

        instr(0, 2'b01, 1'b0, 5, n);
        check("mem_wait5_latency", n, 9);
        instr(3, 2'b00, 1'b0, 0, n);
        check("fetch_wait3_latency", n, 8);
        instr(0, 2'b01, 1'b0, 15, n);
        check("mem_edge_latency", n, 19);
        check("mem_edge_err", bus.err, 0);
        check("mem_edge_state", bus.state, ST_FETCH);
        check("mem_edge_retired", bus.retired, 5);

        apply_reset("rst2");
        start_seq();
        wait_phase(ST_FETCH, 20, 1'b0, to);
`ifdef INSTR_SEQ_TIMEOUT_EN
        check("timeout_flag", to, 1);
        check("timeout_state", bus.state, ST_HALT);
        check("timeout_err", bus.err, 1);
        check("timeout_halted", bus.halted, 1);
        halt_cycles(3);
`else
        check("no_timeout_flag", to, 0);
        check("no_timeout_state", bus.state, ST_FETCH);
        check("no_timeout_count", bus.count, 15);
        check("no_timeout_err", bus.err, 0);
        step(ST_FETCH, 15, 1'b1);
        rest(2'b00, 1'b0, 0);
        check("no_timeout_retired", bus.retired, 1);
`endif
        apply_reset("rst3");

        start_seq();
        instr(0, 2'b11, 1'b0, 0, n);
        check("halt_decode_latency", n, 2);
        halt_cycles(4);
        check("halt_state", bus.state, ST_HALT);
        check("halt_halted", bus.halted, 1);
        apply_reset("rst_in_halt");

        start_seq();
        instr(0, 2'b00, 1'b0, 0, n);
        step(ST_FETCH, 0, 1'b1);
        cycle(ST_DECODE, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        step(ST_EXEC, 0, 1'b1);
        rst = 1'b1;
        step(ST_EXEC, 1, 1'b1);
        rst = 1'b0;
        m_ret = 0;
        m_err = 1'b0;
        check_reset_vals("rst_mid_exec");

        start_seq();
        instr(1, 2'b01, 1'b0, 2, n);
        check("final_mem_latency", n, 7);
        check("final_retired", bus.retired, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Cycle-level instruction sequencer for the FSM processor. It owns the 3-bit control state and the 4-bit per-state step count, and consumes the decoded opcode and compare flag. It produces the fetch, ALU, memory, writeback and PC strobes that drive the datapath. It also maintains a retired-instruction counter and halts on a halt opcode or a memory timeout.

## Interface
Parameters:
- RETIRE_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- opcode  in  2  current instruction opcode; sampled only in DECODE. Encoding: 00 ALU, 01 memory, 10 conditional jump, 11 halt.
- cmp  in  1  compare result; sampled only in DECODE.
- mem_ready  in  1  memory handshake completion; sampled in FETCH and MEM.
- state  out  3  current control state.
- count  out  4  step count within current state.
- fetch_en  out  1  high in FETCH.
- alu_en  out  1  high in EXEC.
- mem_req  out  1  high in MEM.
- wb_en  out  1  high in WRITE when latched opcode is not 10.
- pc_inc  out  1  high in WRITE.
- pc_load  out  1  high in BRANCH.
- halted  out  1  high in HALT.
- err  out  1  sticky timeout flag.
- retired  out  RETIRE_W  count of completed instructions.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, BRANCH=5, WRITE=6, HALT=7.
- IDLE: moves to FETCH when start=1.
- FETCH: moves to DECODE when mem_ready=1.
- DECODE: lasts exactly one cycle.
  - Latches opcode into op_q and cmp into cmp_q.
  - Next state: 00 -> EXEC; 01 -> MEM; 10 with cmp=1 -> BRANCH; 10 with cmp=0 -> WRITE (not taken); 11 -> HALT.
- EXEC: lasts exactly two cycles (count 0 and 1); moves to WRITE at count==1.
- MEM: moves to WRITE when mem_ready=1.
- BRANCH: one cycle, then FETCH.
- WRITE: one cycle, then FETCH.
- HALT: absorbing; only rst exits it. start is ignored.
- count behaviour:
  - Cleared to 0 on every state transition.
  - Held at 0 in IDLE and HALT.
  - Otherwise increments each cycle, saturating at 15 (no wrap).
- retired: increments by 1 on the cycle that leaves WRITE or BRANCH; wraps modulo 2^RETIRE_W.
- All strobes are decoded from registered state, count and op_q only. There are no combinational input-to-output paths.
- Timeout: a wait in FETCH or MEM with count==15 and mem_ready=0. mem_ready=1 on that same cycle takes priority and the normal transition occurs. Timeout handling is set under Configuration.

## Timing
- Reset values: state=0 (IDLE), count=0, op_q=00, cmp_q=0, err=0, retired=0. All strobes are 0.
- rst takes priority over every other input, including in the middle of an instruction or while in HALT. Asserting rst returns the block to IDLE on the next edge.
- Latency for an ALU instruction with zero-wait memory: 5 cycles, start of FETCH to start of next FETCH (FETCH 1, DECODE 1, EXEC 2, WRITE 1).
- Zero-wait memory instruction: 4 cycles.
- Jump taken: 3 cycles (FETCH, DECODE, BRANCH).
- Jump not taken: 3 cycles (FETCH, DECODE, WRITE with wb_en=0 and pc_inc=1).
- Each extra cycle mem_ready is low in FETCH or MEM adds one cycle.
- start is sampled on the rising edge while in IDLE. FETCH begins on the following cycle.

## Configuration
- INSTR_SEQ_TIMEOUT_EN defined:
  - A timeout in FETCH or MEM sets err=1 and moves to HALT on the next edge.
  - err stays at 1 until rst.
- INSTR_SEQ_TIMEOUT_EN undefined:
  - No timeout exists; the block waits in FETCH or MEM indefinitely.
  - count stays saturated at 15; err is tied to 0.

## Test plan
- Reset then start=1 with mem_ready=1 and opcode=00: states 1,2,3,3,6,1. alu_en high for 2 cycles. wb_en and pc_inc high for 1 cycle. retired=1.
- opcode=10 with cmp=1, then again with cmp=0: first gives pc_load pulse and states 1,2,5,1. Second gives states 1,2,6,1 with wb_en=0 and pc_inc=1. retired=2.
- opcode=01 with mem_ready held low 5 cycles in MEM: count reads 0..5 in MEM. Transition to WRITE on the mem_ready=1 cycle; total instruction is 9 cycles.
- mem_ready low for 20 cycles in FETCH:
  - With INSTR_SEQ_TIMEOUT_EN: err=1, state=7 after count reaches 15.
  - Without it: state stays 1, count stays 15, err=0.
- mem_ready=1 exactly when count==15 in MEM with the macro defined: goes to WRITE, err stays 0.
- opcode=11 gives HALT with halted=1, and start pulses are ignored. rst asserted in HALT and again mid-EXEC returns the block to IDLE with every output at its reset value.
